// File: rtl/shift_sequencer.sv
// Sequencer for the 64-bit LSL/ASR step shifter: accepts a variable-distance shift
// command, loads the operand, issues the minimum 8-bit/1-bit step sequence and returns the result.
module shift_sequencer #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             sh_load,
    output logic             sh_ena,
    output logic [1:0]       sh_amount,
    output logic [WIDTH-1:0] sh_data,
    input  logic [WIDTH-1:0] sh_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W:0]   WIDTH_X = (CNT_W + 1)'(WIDTH);
    localparam logic [CNT_W-1:0] BYTE_STEP = CNT_W'(8);
    localparam logic [CNT_W-1:0] BIT_STEP  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_clamped;
    logic [CNT_W-1:0] rem_next;

    // Distances beyond the datapath width saturate to a full-width shift
    assign cnt_clamped = ({1'b0, cmd_count} > WIDTH_X) ? WIDTH_X[CNT_W-1:0] : cmd_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        rem_next  = rem_q;
        cmd_ready = 1'b0;
        sh_load   = 1'b0;
        sh_ena    = 1'b0;
        sh_amount = 2'b00;
        rsp_valid = 1'b0;
        rsp_data  = sh_q;
        sh_data   = cmd_data;
        busy      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                // Reset forces the state to IDLE asynchronously; keep the shifter untouched meanwhile
                sh_load   = cmd_valid & ~rst;
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    rem_d   = cnt_clamped;
                    state_d = (cnt_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sh_ena = 1'b1;
                // Amount encoding is {arith_right, byte_step}
                if (rem_q >= BYTE_STEP) begin
                    sh_amount = {dir_q, 1'b1};
                    rem_next  = rem_q - BYTE_STEP;
                end else begin
                    sh_amount = {dir_q, 1'b0};
                    rem_next  = rem_q - BIT_STEP;
                end
                rem_d = rem_next;
                if (rem_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the step shifter.
module tb_shift_sequencer;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 7;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             sh_load;
    logic             sh_ena;
    logic [1:0]       sh_amount;
    logic [WIDTH-1:0] sh_data;
    logic [WIDTH-1:0] sh_q;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_viol   = 0;
    logic [1:0] amt_q[$];

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_dir(cmd_dir), .cmd_count(cmd_count),
        .sh_load(sh_load), .sh_ena(sh_ena), .sh_amount(sh_amount),
        .sh_data(sh_data), .sh_q(sh_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step shifter model: 00=LSL1, 01=LSL8, 10=ASR1, 11=ASR8; no reset
    always @(posedge clk) begin
        if (sh_load) begin
            sh_q <= sh_data;
        end else if (sh_ena) begin
            case (sh_amount)
                2'b00: sh_q <= sh_q << 1;
                2'b01: sh_q <= sh_q << 8;
                2'b10: sh_q <= $signed(sh_q) >>> 1;
                default: sh_q <= $signed(sh_q) >>> 8;
            endcase
        end
    end

    // Step recorder and protocol watch
    always @(posedge clk) begin
        if (sh_ena) amt_q.push_back(sh_amount);
        if ((sh_ena && !busy) || (sh_ena && sh_load)) n_viol++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Issue one command and wait (bounded) for rsp_valid; leaves the DUT in DONE
    task automatic run_cmd(input logic [WIDTH-1:0] d, input logic dr, input logic [CNT_W-1:0] c,
                           output int lat, output logic [WIDTH-1:0] rd);
        amt_q.delete();
        cmd_valid = 1'b1; cmd_data = d; cmd_dir = dr; cmd_count = c;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_data;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b0;
        cmd_data = '0; cmd_dir = 1'b0; cmd_count = '0;
        #3;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
        n_checks++; if (sh_load !== 1'b0) $display("FAIL reset_sh_load got %b exp 0", sh_load); else n_pass++;
        n_checks++; if (sh_ena !== 1'b0) $display("FAIL reset_sh_ena got %b exp 0", sh_ena); else n_pass++;
        n_checks++; if (sh_amount !== 2'b00) $display("FAIL reset_sh_amount got %b exp 00", sh_amount); else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lsl9();
        int lat; logic [WIDTH-1:0] rd;
        run_cmd(64'h0000_0000_0000_0001, 1'b0, 7'd9, lat, rd);
        n_checks++; if (amt_q.size() !== 2) $display("FAIL lsl9_steps got %0d exp 2", amt_q.size()); else n_pass++;
        if (amt_q.size() == 2) begin
            n_checks++; if (amt_q[0] !== 2'b01) $display("FAIL lsl9_amt0 got %b exp 01", amt_q[0]); else n_pass++;
            n_checks++; if (amt_q[1] !== 2'b00) $display("FAIL lsl9_amt1 got %b exp 00", amt_q[1]); else n_pass++;
        end
        n_checks++; if (lat !== 3) $display("FAIL lsl9_latency got %0d exp 3", lat); else n_pass++;
        n_checks++; if (rd !== 64'h0000_0000_0000_0200) $display("FAIL lsl9_data got %h exp 0000000000000200", rd); else n_pass++;
        finish_rsp();
        n_checks++; if (busy !== 1'b0) $display("FAIL lsl9_idle_after got busy=%b exp 0", busy); else n_pass++;
    endtask

    task automatic test_asr4();
        int lat; logic [WIDTH-1:0] rd;
        run_cmd(64'h8000_0000_0000_0000, 1'b1, 7'd4, lat, rd);
        n_checks++; if (amt_q.size() !== 4) $display("FAIL asr4_steps got %0d exp 4", amt_q.size()); else n_pass++;
        foreach (amt_q[i]) begin
            n_checks++; if (amt_q[i] !== 2'b10) $display("FAIL asr4_amt%0d got %b exp 10", i, amt_q[i]); else n_pass++;
        end
        n_checks++; if (lat !== 5) $display("FAIL asr4_latency got %0d exp 5", lat); else n_pass++;
        n_checks++; if (rd !== 64'hF800_0000_0000_0000) $display("FAIL asr4_data got %h exp f800000000000000", rd); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_zero_count();
        int lat; logic [WIDTH-1:0] rd;
        run_cmd(64'hDEAD_BEEF_0123_4567, 1'b0, 7'd0, lat, rd);
        n_checks++; if (amt_q.size() !== 0) $display("FAIL zero_steps got %0d exp 0", amt_q.size()); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL zero_latency got %0d exp 1", lat); else n_pass++;
        n_checks++; if (rd !== 64'hDEAD_BEEF_0123_4567) $display("FAIL zero_data got %h exp deadbeef01234567", rd); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_clamp();
        int lat; logic [WIDTH-1:0] rd;
        run_cmd(64'h8000_0000_0000_0001, 1'b1, 7'd100, lat, rd);
        n_checks++; if (amt_q.size() !== 8) $display("FAIL clamp_r_steps got %0d exp 8", amt_q.size()); else n_pass++;
        foreach (amt_q[i]) begin
            n_checks++; if (amt_q[i] !== 2'b11) $display("FAIL clamp_r_amt%0d got %b exp 11", i, amt_q[i]); else n_pass++;
        end
        n_checks++; if (lat !== 9) $display("FAIL clamp_r_latency got %0d exp 9", lat); else n_pass++;
        n_checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL clamp_r_data got %h exp ffffffffffffffff", rd); else n_pass++;
        finish_rsp();
        run_cmd(64'h8000_0000_0000_0001, 1'b0, 7'd100, lat, rd);
        n_checks++; if (amt_q.size() !== 8) $display("FAIL clamp_l_steps got %0d exp 8", amt_q.size()); else n_pass++;
        n_checks++; if (lat !== 9) $display("FAIL clamp_l_latency got %0d exp 9", lat); else n_pass++;
        n_checks++; if (rd !== 64'h0) $display("FAIL clamp_l_data got %h exp 0", rd); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int lat; logic [WIDTH-1:0] rd;
        int guard;
        run_cmd(64'h3, 1'b0, 7'd2, lat, rd);
        n_checks++; if (rd !== 64'hC) $display("FAIL bp_data got %h exp c", rd); else n_pass++;
        cmd_valid = 1'b1; cmd_data = 64'h5; cmd_dir = 1'b0; cmd_count = 7'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++; if (rsp_data !== 64'hC) $display("FAIL bp_hold_data%0d got %h exp c", i, rsp_data); else n_pass++;
            n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_hold_ready%0d got %b exp 0", i, cmd_ready); else n_pass++;
            n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid%0d got %b exp 1", i, rsp_valid); else n_pass++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_release_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (sh_load !== 1'b1) $display("FAIL bp_release_load got %b exp 1", sh_load); else n_pass++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL bp_pending_accept got busy=%b exp 1", busy); else n_pass++;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++; if (rsp_data !== 64'hA) $display("FAIL bp_pending_data got %h exp a", rsp_data); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_rsp_ready_idle();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL idle_rsp_ready_valid got %b exp 0", rsp_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_rsp_ready_busy got %b exp 0", busy); else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [WIDTH-1:0] rd;
        cmd_valid = 1'b1; cmd_data = 64'h1; cmd_dir = 1'b0; cmd_count = 7'd20;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (sh_ena !== 1'b1) $display("FAIL mid_in_shift got sh_ena=%b exp 1", sh_ena); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (sh_ena !== 1'b0) $display("FAIL mid_rst_sh_ena got %b exp 0", sh_ena); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_rst_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_rst_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_cmd(64'h1, 1'b0, 7'd1, lat, rd);
        n_checks++; if (lat !== 2) $display("FAIL mid_after_latency got %0d exp 2", lat); else n_pass++;
        n_checks++; if (rd !== 64'h2) $display("FAIL mid_after_data got %h exp 2", rd); else n_pass++;
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_lsl9();
        test_asr4();
        test_zero_count();
        test_clamp();
        test_backpressure();
        test_rsp_ready_idle();
        test_reset_mid();
        n_checks++; if (n_viol !== 0) $display("FAIL ena_protocol got %0d violations exp 0", n_viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Controller that drives the 64-bit load/enable/amount shift register (shift datapath with codes 00=LSL1, 01=LSL8, 10=ASR1, 11=ASR8).
- Accepts a variable-distance shift command (0..127 bits, logical left or arithmetic right) over a valid/ready handshake.
- Loads the operand into the shifter, then issues the minimum sequence of 8-bit and 1-bit steps.
- Returns the shifter output over a valid/ready response channel.

Parameters:
- WIDTH, 64, datapath width; must equal the shifter width and be a multiple of 8.
- CNT_W, 7, width of the command shift-distance field.

Ports:
- clk  input  1  rising-edge clock, shared with the shifter.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_data  input  WIDTH  operand to shift.
- cmd_dir  input  1  0 = logical left, 1 = arithmetic right.
- cmd_count  input  CNT_W  shift distance in bits.
- sh_load  output  1  to shifter load.
- sh_ena  output  1  to shifter ena.
- sh_amount  output  2  to shifter amount.
- sh_data  output  WIDTH  to shifter data.
- sh_q  input  WIDTH  from shifter q.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  shifted result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, SHIFT, DONE. State register and remaining-count register rem (CNT_W bits) and dir register are the only flops. All outputs decode from state, rem and dir, except sh_data, which passes cmd_data through.
- Reset (async, any time including mid-sequence):
  - state=IDLE, rem=0, dir=0.
  - Outputs: cmd_ready=1, busy=0, rsp_valid=0, sh_load=0, sh_ena=0, sh_amount=00.
  - The shifter contents are not cleared.
- IDLE:
  - cmd_ready=1.
  - sh_load = cmd_valid, combinationally; sh_data = cmd_data.
  - On cmd_valid & cmd_ready: latch dir=cmd_dir and rem=min(cmd_count, WIDTH).
  - Next state is DONE if the clamped count is 0, else SHIFT.
- SHIFT: cmd_ready=0, sh_ena=1, sh_load=0.
  - If rem>=8: sh_amount = dir ? 11 : 01, and rem -= 8.
  - Else: sh_amount = dir ? 10 : 00, and rem -= 1.
  - When the value of rem after this cycle is 0, next state is DONE.
- DONE:
  - rsp_valid=1, rsp_data=sh_q. The shifter registered its final step on the edge entering DONE.
  - sh_ena=0, sh_load=0, and cmd_ready=0, so sh_q stays stable.
  - On rsp_ready, go to IDLE. With no rsp_ready, hold indefinitely with rsp_data stable.
- Latency:
  - The accept edge is cycle 0.
  - rsp_valid rises after 1 + floor(n/8) + (n mod 8) cycles, where n is the clamped count.
  - For n=0, rsp_valid is high in the cycle after accept.
- Clamp: counts of 64..127 behave as 64, i.e. eight ASR8/LSL8 steps. The result is all-zero for left shifts and all sign bits for right shifts.
- No command overlap: a new command can be accepted no earlier than the cycle after the rsp handshake. cmd_valid in SHIFT or DONE is ignored and stays pending.
- When not busy, sh_ena is never asserted. sh_load and sh_ena are never high in the same cycle.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Reset, then cmd_data=64'h0000_0000_0000_0001, dir=0, count=9.
  - Required: one LSL8 step then one LSL1 step, with sh_amount sequence 01,00.
  - Required: rsp_valid 3 cycles after accept, rsp_data=64'h0000_0000_0000_0200.
- cmd_data=64'h8000_0000_0000_0000, dir=1, count=4.
  - Required: four ASR1 steps, sh_amount=10 each.
  - Required: rsp_data=64'hF800_0000_0000_0000, latency 5.
- count=0, data=64'hDEAD_BEEF_0123_4567.
  - Required: no sh_ena pulse, rsp_valid in the next cycle, rsp_data equals cmd_data.
- count=100, dir=1, data=64'h8000_0000_0000_0001.
  - Required: clamped to 64, eight ASR8 steps, rsp_data=64'hFFFF_FFFF_FFFF_FFFF.
  - Same command with dir=0: required rsp_data=0.
- Response backpressure:
  - Hold rsp_ready=0 for 10 cycles in DONE. Required: rsp_data stable, cmd_ready=0, and a pending cmd_valid is not accepted.
  - Release rsp_ready. Required: IDLE and accept of the pending command on the following edge.
- Reset mid-sequence:
  - Assert rst during SHIFT of a count=20 command. Required: the same cycle shows busy=0, sh_ena=0, rsp_valid=0, cmd_ready=1.
  - After deassert, a new count=1 left shift of 64'h1 returns 64'h2.
